// File: rtl/packet_reorder_buffer_if.sv
// Stream and verdict bundle for packet_reorder_buffer.
// master: the side that feeds packets/verdicts and accepts egress.
// slave: the reorder buffer itself.
interface packet_reorder_buffer_if #(
    parameter int unsigned TAG_WIDTH  = 6,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8
);
    logic [DATA_WIDTH-1:0] in_TDATA;
    logic [KEEP_WIDTH-1:0] in_TKEEP;
    logic                  in_TLAST;
    logic                  in_TVALID;
    logic                  in_TREADY;
    logic [TAG_WIDTH-1:0]  in_tag;

    logic                  status_valid;
    logic [TAG_WIDTH-1:0]  status_tag;
    logic                  status_accept;

    logic [DATA_WIDTH-1:0] out_TDATA;
    logic [KEEP_WIDTH-1:0] out_TKEEP;
    logic                  out_TLAST;
    logic                  out_TVALID;
    logic                  out_TREADY;

    logic [TAG_WIDTH-1:0]  head_tag;
    logic                  status_err;

    modport master (
        output in_TDATA, in_TKEEP, in_TLAST, in_TVALID, in_tag,
        output status_valid, status_tag, status_accept,
        output out_TREADY,
        input  in_TREADY, out_TDATA, out_TKEEP, out_TLAST, out_TVALID,
        input  head_tag, status_err
    );

    modport slave (
        input  in_TDATA, in_TKEEP, in_TLAST, in_TVALID, in_tag,
        input  status_valid, status_tag, status_accept,
        input  out_TREADY,
        output in_TREADY, out_TDATA, out_TKEEP, out_TLAST, out_TVALID,
        output head_tag, status_err
    );
endinterface

// File: rtl/packet_reorder_buffer.sv
// Tag-addressed packet store that releases packets strictly in tag order.
// Accepted packets stream out; rejected or overflowed packets are freed silently.
// Optional counters enabled by defining REORDER_STATS_EN.
module packet_reorder_buffer #(
    parameter int unsigned TAG_WIDTH  = 6,
    parameter int unsigned NUM_SLOTS  = 4,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned MAX_BEATS  = 6,
    parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic clk,
    input  logic rst,
    packet_reorder_buffer_if.slave bus
`ifdef REORDER_STATS_EN
    ,
    output logic [31:0] accept_count,
    output logic [31:0] reject_count,
    output logic [31:0] overflow_count
`endif
);
    localparam int unsigned SW = $clog2(NUM_SLOTS);
    localparam int unsigned BW = $clog2(MAX_BEATS);
    localparam int unsigned CW = $clog2(MAX_BEATS + 1);

    typedef enum logic [1:0] {StIdle, StSend, StDrop, StFree} state_e;

    // Per-slot bookkeeping
    logic [TAG_WIDTH-1:0]  tag_q [NUM_SLOTS];
    logic [TAG_WIDTH-1:0]  tag_d [NUM_SLOTS];
    logic [CW-1:0]         cnt_q [NUM_SLOTS];
    logic [CW-1:0]         cnt_d [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]  tagged_q, tagged_d;  // stored tag is meaningful
    logic [NUM_SLOTS-1:0]  cmpl_q, cmpl_d;
    logic [NUM_SLOTS-1:0]  ovf_q, ovf_d;
    logic [NUM_SLOTS-1:0]  vv_q, vv_d;
    logic [NUM_SLOTS-1:0]  vd_q, vd_d;
    logic                  err_q, err_d;

    // Beat storage, no reset needed: validity is tracked by cnt_q
    logic [DATA_WIDTH-1:0] data_mem [NUM_SLOTS][MAX_BEATS];
    logic [KEEP_WIDTH-1:0] keep_mem [NUM_SLOTS][MAX_BEATS];

    // Egress
    state_e                state_q, state_d;
    logic [TAG_WIDTH-1:0]  head_q, head_d;
    logic [BW-1:0]         ptr_q, ptr_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [KEEP_WIDTH-1:0] out_keep_q, out_keep_d;

    logic [SW-1:0] wslot, vslot, hslot;
    logic          in_ready, in_fire, wr_beat, releasable, free_now;

    assign wslot    = bus.in_tag[SW-1:0];
    assign vslot    = bus.status_tag[SW-1:0];
    assign hslot    = head_q[SW-1:0];
    assign free_now = (state_q == StFree);

    // Slot is writable when empty or still filling with this same tag
    assign in_ready = !rst && !cmpl_q[wslot] &&
                      (!tagged_q[wslot] || (tag_q[wslot] == bus.in_tag));
    assign in_fire  = bus.in_TVALID && in_ready;
    assign wr_beat  = in_fire && (cnt_q[wslot] < CW'(MAX_BEATS));

    assign releasable = cmpl_q[hslot] && vv_q[hslot] && (tag_q[hslot] == head_q);

    // Slot next state: free first, then verdict, then ingress beat
    always_comb begin
        tag_d    = tag_q;
        cnt_d    = cnt_q;
        tagged_d = tagged_q;
        cmpl_d   = cmpl_q;
        ovf_d    = ovf_q;
        vv_d     = vv_q;
        vd_d     = vd_q;
        err_d    = err_q;
        if (free_now) begin
            tagged_d[hslot] = 1'b0;
            cnt_d[hslot]    = '0;
            cmpl_d[hslot]   = 1'b0;
            ovf_d[hslot]    = 1'b0;
            vv_d[hslot]     = 1'b0;
            vd_d[hslot]     = 1'b0;
        end
        // A slot being freed this cycle is treated as already clear for verdicts
        if (bus.status_valid) begin
            if (vv_d[vslot]) begin
                err_d = 1'b1;
            end else begin
                vv_d[vslot] = 1'b1;
                vd_d[vslot] = bus.status_accept;
                if (!tagged_d[vslot]) begin
                    tagged_d[vslot] = 1'b1;
                    tag_d[vslot]    = bus.status_tag;
                end
            end
        end
        if (in_fire) begin
            tagged_d[wslot] = 1'b1;
            tag_d[wslot]    = bus.in_tag;
            if (wr_beat) begin
                cnt_d[wslot] = cnt_q[wslot] + CW'(1);
            end else begin
                ovf_d[wslot] = 1'b1;
            end
            if (bus.in_TLAST) begin
                cmpl_d[wslot] = 1'b1;
            end
        end
    end

    // Beat storage write
    always_ff @(posedge clk) begin
        if (wr_beat) begin
            data_mem[wslot][cnt_q[wslot][BW-1:0]] <= bus.in_TDATA;
            keep_mem[wslot][cnt_q[wslot][BW-1:0]] <= bus.in_TKEEP;
        end
    end

    // Egress FSM next state and registered output data
    always_comb begin
        state_d     = state_q;
        head_d      = head_q;
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        unique case (state_q)
            StIdle: begin
                if (releasable) begin
                    if (!vd_q[hslot] || ovf_q[hslot]) begin
                        state_d = StDrop;
                    end else begin
                        state_d     = StSend;
                        ptr_d       = '0;
                        out_valid_d = 1'b1;
                        out_last_d  = (cnt_q[hslot] == CW'(1));
                        out_data_d  = data_mem[hslot][0];
                        out_keep_d  = keep_mem[hslot][0];
                    end
                end
            end
            StSend: begin
                if (bus.out_TREADY) begin
                    if (out_last_q) begin
                        state_d     = StFree;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        out_data_d  = '0;
                        out_keep_d  = '0;
                    end else begin
                        ptr_d      = ptr_q + BW'(1);
                        out_last_d = ((CW'(ptr_d) + CW'(1)) == cnt_q[hslot]);
                        out_data_d = data_mem[hslot][ptr_d];
                        out_keep_d = keep_mem[hslot][ptr_d];
                    end
                end
            end
            StDrop: begin
                state_d = StFree;
            end
            StFree: begin
                state_d = StIdle;
                head_d  = head_q + TAG_WIDTH'(1);
            end
        endcase
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q       <= '{default: '0};
            cnt_q       <= '{default: '0};
            tagged_q    <= '0;
            cmpl_q      <= '0;
            ovf_q       <= '0;
            vv_q        <= '0;
            vd_q        <= '0;
            err_q       <= 1'b0;
            state_q     <= StIdle;
            head_q      <= '0;
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
        end else begin
            tag_q       <= tag_d;
            cnt_q       <= cnt_d;
            tagged_q    <= tagged_d;
            cmpl_q      <= cmpl_d;
            ovf_q       <= ovf_d;
            vv_q        <= vv_d;
            vd_q        <= vd_d;
            err_q       <= err_d;
            state_q     <= state_d;
            head_q      <= head_d;
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
        end
    end

    assign bus.in_TREADY  = in_ready;
    assign bus.out_TVALID = out_valid_q;
    assign bus.out_TLAST  = out_last_q;
    assign bus.out_TDATA  = out_data_q;
    assign bus.out_TKEEP  = out_keep_q;
    assign bus.head_tag   = head_q;
    assign bus.status_err = err_q;

`ifdef REORDER_STATS_EN
    logic [31:0] acc_cnt_q, rej_cnt_q, ovf_cnt_q;

    // Outcome counters, bumped once per packet as it is freed; saturating
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_cnt_q <= '0;
            rej_cnt_q <= '0;
            ovf_cnt_q <= '0;
        end else if (free_now) begin
            if (ovf_q[hslot]) begin
                if (ovf_cnt_q != '1) ovf_cnt_q <= ovf_cnt_q + 32'd1;
            end else if (!vd_q[hslot]) begin
                if (rej_cnt_q != '1) rej_cnt_q <= rej_cnt_q + 32'd1;
            end else begin
                if (acc_cnt_q != '1) acc_cnt_q <= acc_cnt_q + 32'd1;
            end
        end
    end

    assign accept_count   = acc_cnt_q;
    assign reject_count   = rej_cnt_q;
    assign overflow_count = ovf_cnt_q;
`endif
endmodule

// File: doc/packet_reorder_buffer.md
Name: packet_reorder_buffer

Overview:
- Multi-slot, tag-addressed packet store between the filter cores and the egress AXI-Stream port.
- Packets arrive out of order, each carrying a reorder tag. Each tag receives a separate accept/reject verdict, which may arrive before or after the packet.
- Packets are released strictly in tag order: accepted packets are streamed out, rejected or overflowed packets are silently freed.
- Successor to circular_buffer. Adds TKEEP, a registered verdict interface instead of a combinational status lookup, wrapping sequence tags, overflow handling and drain pipelining.

Parameters:
- TAG_WIDTH, 6, width of the sequence tag; head tag wraps modulo 2^TAG_WIDTH.
- NUM_SLOTS, 4, number of packet slots; power of 2, at most 2^TAG_WIDTH; slot index = tag[log2(NUM_SLOTS)-1:0].
- DATA_WIDTH, 64, TDATA width; multiple of 8.
- MAX_BEATS, 6, maximum beats stored per slot.
- KEEP_WIDTH, DATA_WIDTH/8, TKEEP width (derived).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_TDATA  in  DATA_WIDTH  ingress data
- in_TKEEP  in  KEEP_WIDTH  ingress byte enables
- in_TLAST  in  1  ingress end of packet
- in_TVALID  in  1  ingress valid
- in_TREADY  out  1  ingress ready
- in_tag  in  TAG_WIDTH  tag of current ingress packet; held constant for the whole packet
- status_valid  in  1  verdict strobe
- status_tag  in  TAG_WIDTH  tag the verdict applies to
- status_accept  in  1  1 = accept, 0 = reject
- out_TDATA  out  DATA_WIDTH  egress data
- out_TKEEP  out  KEEP_WIDTH  egress byte enables
- out_TLAST  out  1  egress end of packet
- out_TVALID  out  1  egress valid
- out_TREADY  in  1  egress ready
- head_tag  out  TAG_WIDTH  next tag to be released
- status_err  out  1  sticky: verdict collision

Behaviour:
- Reset is asynchronous and takes effect immediately:
  - all slots EMPTY, beat counts 0, verdict flags 0;
  - head_tag=0, out FSM=IDLE;
  - out_TVALID=0, out_TLAST=0, out_TDATA=0, out_TKEEP=0, status_err=0, in_TREADY=0.
  - Reset mid-packet discards all stored and partially stored data.
- Per-slot state: stored tag, beat count, complete flag, overflow flag, verdict_valid, verdict.
- Ingress:
  - in_TREADY=1 (combinational on in_tag) iff not rst and the addressed slot is not complete.
  - A slot is writable when it is EMPTY, or FILLING with the same stored tag.
  - Each handshake writes TDATA/TKEEP at the current beat index, increments the count and latches the tag.
  - TLAST sets complete.
  - Beats beyond MAX_BEATS are accepted and discarded, and the overflow flag is set.
- Verdict:
  - On status_valid, if the addressed slot has verdict_valid=0, record the verdict and tag.
  - Otherwise ignore it and set status_err.
  - A verdict may precede the first beat; it is kept until release.
  - A verdict arriving on the same edge as TLAST is recorded on that edge.
- Releasable: head slot has complete=1, verdict_valid=1, and stored tag == head_tag.
- Egress FSM:
  - IDLE: if releasable and (verdict=0 or overflow=1) -> DROP; if releasable and accepted -> SEND, beat ptr=0.
  - SEND: out_TVALID=1 with registered beat data. out_TLAST=1 on beat count-1. On handshake, advance the ptr; on handshake of the last beat -> FREE.
  - DROP: 1 cycle -> FREE.
  - FREE: clear the slot, head_tag <= head_tag+1 (wrapping), -> IDLE.
- Latency: slot becomes releasable at edge E; FSM leaves IDLE at edge E+1; first out_TVALID is high after E+1.
- Slot freeing:
  - A slot freed in FREE is writable on the next cycle; no same-cycle write/free is possible on one slot.
  - A slot is never overwritten before release; ingress backpressures instead.
- out_TDATA and out_TVALID hold stable while out_TVALID=1 and out_TREADY=0.

Optional Feature:
- Macro: REORDER_STATS_EN.
- When defined:
  - adds outputs accept_count[31:0], reject_count[31:0] and overflow_count[31:0];
  - each counter increments once per packet in FREE, according to its outcome (overflow takes precedence over reject);
  - counters saturate at all-ones and reset to 0.
- When undefined: the ports and logic are absent and the behaviour is otherwise identical.

Test Plan:
- Tags 1,0,2 sent, then accepts for 0,1,2 -> egress order 0,1,2; beat data and TKEEP match; head_tag=3.
- Tag 0 rejected before it arrives, tag 1 accepted -> tag 0 dropped with no out_TVALID, tag 1 output; head_tag=2.
- 8-beat packet with MAX_BEATS=6, accepted -> dropped; head advances; with REORDER_STATS_EN, overflow_count=1.
- Tag 4 sent while slot 0 still holds unreleased tag 0 -> in_TREADY=0 until tag 0 is freed, then tag 4 stored and released after head wraps.
- Second verdict for the same tag while the first is pending -> status_err=1; first verdict used.
- out_TREADY random 40% low with rst asserted mid-packet -> outputs 0 immediately, head_tag=0, and a subsequent packet with tag 0 is output correctly.
